// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the slave and by the SPI master block:
// FSM state encoding, the default word width and the four CPOL/CPHA modes.
package spi_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  // Mode number is {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Local-side word interface of the SPI slave (towards a register file or FIFO).
// With SPI_SLAVE_OVERRUN_FLAG_EN defined it also carries rx_ack and overrun.
interface spi_slave_if #(
  parameter int DATA_W = spi_pkg::DEFAULT_DATA_W
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_ack;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
  logic              rx_ack;
  logic              overrun;
`endif

`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
  modport slave (
    input  tx_data, rx_ack,
    output tx_ack, rx_data, rx_valid, busy, overrun
  );
  modport master (
    output tx_data, rx_ack,
    input  tx_ack, rx_data, rx_valid, busy, overrun
  );
`else
  modport slave (
    input  tx_data,
    output tx_ack, rx_data, rx_valid, busy
  );
  modport master (
    output tx_data,
    input  tx_ack, rx_data, rx_valid, busy
  );
`endif

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by an edge
// detector. rst_val presets every flop to the pin's inactive level so that
// leaving reset never produces a spurious edge.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last;

  // Shift the pin through the synchronizer and keep a delayed copy for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{rst_val}};
      last <= rst_val;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      last <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~last;
  assign fall = ~sync[SYNC_STAGES-1] & last;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled sclk/ss_n/mosi, all four CPOL/CPHA modes, full-duplex
// MSB-first words, multi-word frames. Optional macro SPI_SLAVE_OVERRUN_FLAG_EN
// adds an rx_ack input and an overrun pulse output on the bus interface.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  spi_slave_if.slave bus
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  spi_state_t        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_data_r;
  logic              word_done;
  logic              tx_ack_r;
  logic              rx_valid_r;
  logic              busy_r;
`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
  logic              rx_pending;
  logic              overrun_r;
`endif

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .rst_val(cpol), .din(sclk),
    .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk(clk), .rst(rst), .rst_val(1'b1), .din(ss_n),
    .rise(ss_rise), .fall(ss_fall)
  );

  // mosi is retimed through the same depth as sclk so data and edge stay aligned
  always_ff @(posedge clk) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  // Frame FSM. tx_shift holds the bits not yet driven on miso; with cpha=1 the
  // whole word is kept after a load so the first lead edge re-drives the MSB.
  // A completed word is committed one clk after the wrap (word_done), and that
  // commit still happens if the frame ended on the same clk as the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      rx_data_r  <= '0;
      word_done  <= 1'b0;
      tx_ack_r   <= 1'b0;
      rx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
      rx_pending <= 1'b0;
      overrun_r  <= 1'b0;
`endif
    end else begin
      tx_ack_r   <= 1'b0;
      rx_valid_r <= 1'b0;
      word_done  <= 1'b0;

      if (word_done) begin
        rx_data_r  <= rx_shift;
        rx_valid_r <= 1'b1;
      end

`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
      overrun_r <= 1'b0;
      if (word_done) begin
        rx_pending <= 1'b1;
        if (rx_pending) overrun_r <= 1'b1;
      end else if (bus.rx_ack) begin
        rx_pending <= 1'b0;
      end
`endif

      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_shift <= cpha ? bus.tx_data : (bus.tx_data << 1);
            tx_ack_r <= 1'b1;
            miso     <= bus.tx_data[DATA_W-1];
            busy_r   <= 1'b1;
            miso_oe  <= 1'b1;
            bit_cnt  <= '0;
            state    <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (word_done && !ss_rise) begin
            tx_shift <= bus.tx_data;
            tx_ack_r <= 1'b1;
          end else if (shift_edge) begin
            miso     <= tx_shift[DATA_W-1];
            tx_shift <= tx_shift << 1;
          end

          if (sample_edge) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end

          if (ss_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            busy_r  <= 1'b0;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_ack   = tx_ack_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.busy     = busy_r;
`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
  assign bus.overrun  = overrun_r;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: a bit-banged SPI master drives table-driven and
// randomized frames; expected words come from the frame description itself.
// Builds with or without SPI_SLAVE_OVERRUN_FLAG_EN.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int SYNC = 2;
  localparam int NVEC = 15;

  typedef struct {
    logic [1:0]  mode;
    int          nbits;
    int          half;
    logic [23:0] mosi_w;
    logic [23:0] tx_w;
    int          exp_nrx;
    logic [23:0] exp_rx;
    logic [23:0] exp_miso;
  } vec_t;

  logic clk = 1'b0;
  logic rst, cpol, cpha, sclk, ss_n, mosi;
  logic miso, miso_oe;

  spi_slave_if #(.DATA_W(8)) bus_if ();

  spi_slave #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk),
    .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .bus(bus_if)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          ack_cnt = 0;
  int          ovr_cnt = 0;
  int          rxv_cyc = 0;
  logic [7:0]  rx_q[$];
  logic [23:0] cur_tx = '0;
  logic [7:0]  last_rx = '0;
  logic        ack_auto = 1'b0;
  vec_t        vecs[NVEC];

  initial forever #5 clk = ~clk;

  // Cycle counter, used to measure rx_valid latency
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor on the falling edge: collect received words, count tx_ack and
  // present the next transmit word after each capture
  initial forever begin
    @(negedge clk);
    if (bus_if.rx_valid === 1'b1) begin
      rx_q.push_back(bus_if.rx_data);
      rxv_cyc = cyc;
    end
    if (bus_if.tx_ack === 1'b1) begin
      ack_cnt++;
      bus_if.tx_data = (ack_cnt < 3) ? byteOf(cur_tx, ack_cnt) : 8'h00;
    end
`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
    if (bus_if.overrun === 1'b1) ovr_cnt++;
    if (ack_auto) bus_if.rx_ack = bus_if.rx_valid;
`endif
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  function automatic logic [7:0] byteOf(input logic [23:0] v, input int k);
    return v[23-8*k -: 8];
  endfunction

  // Reference: every complete word comes back verbatim on both wires
  function automatic vec_t modelRow(input vec_t v);
    vec_t r;
    r          = v;
    r.exp_nrx  = v.nbits / 8;
    r.exp_rx   = v.mosi_w;
    r.exp_miso = v.tx_w;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame driven by the bench master, then all per-frame checks
  task automatic applyStimulus(input vec_t v);
    logic        p, h, busy_mid, oe_mid;
    logic [23:0] miso_bits;
    int          last_samp, ack_start;
    p         = mode_cpol(v.mode);
    h         = mode_cpha(v.mode);
    miso_bits = '0;
    last_samp = 0;
    rx_q.delete();
    ack_cnt        = 0;
    cur_tx         = v.tx_w;
    bus_if.tx_data = byteOf(v.tx_w, 0);
    cpol = p;
    cpha = h;
    sclk = p;
    mosi = 1'b0;
    waitClk(6);
    ss_n = 1'b0;
    if (!h) mosi = v.mosi_w[23];
    waitClk(v.half);
    busy_mid  = bus_if.busy;
    oe_mid    = miso_oe;
    ack_start = ack_cnt;
    for (int i = 0; i < v.nbits; i++) begin
      if (h) begin
        mosi = v.mosi_w[23-i];
        sclk = ~p;
        waitClk(v.half);
        miso_bits[23-i] = miso;
        sclk = p;
        if (i % 8 == 7) last_samp = cyc;
        waitClk(v.half);
      end else begin
        miso_bits[23-i] = miso;
        sclk = ~p;
        if (i % 8 == 7) last_samp = cyc;
        waitClk(v.half);
        sclk = p;
        if (i < 23) mosi = v.mosi_w[22-i];
        waitClk(v.half);
      end
    end
    ss_n = 1'b1;
    mosi = 1'b0;
    waitClk(SYNC + 1);
    checkOutput("busy_end", 32'(bus_if.busy), 32'd0);
    checkOutput("oe_end", 32'(miso_oe), 32'd0);
    waitClk(4);

    checkOutput("ack_at_fall", ack_start, 1);
    checkOutput("busy_mid", 32'(busy_mid), 32'd1);
    checkOutput("oe_mid", 32'(oe_mid), 32'd1);
    checkOutput("rx_count", rx_q.size(), v.exp_nrx);
    checkOutput("ack_total", ack_cnt, 1 + v.exp_nrx);
    for (int k = 0; k < v.exp_nrx; k++) begin
      if (k < rx_q.size()) checkOutput("rx_word", 32'(rx_q[k]), 32'(byteOf(v.exp_rx, k)));
      checkOutput("miso_word", 32'(byteOf(miso_bits, k)), 32'(byteOf(v.exp_miso, k)));
    end
    if (v.exp_nrx > 0) begin
      checkOutput("rx_latency", rxv_cyc - last_samp, SYNC + 2);
      last_rx = byteOf(v.exp_rx, v.exp_nrx - 1);
    end
    checkOutput("rx_hold", 32'(bus_if.rx_data), 32'(last_rx));
  endtask

  initial begin
    vec_t rv;
    int   sel;
    rst  = 1'b1;
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    bus_if.tx_data = '0;
`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
    bus_if.rx_ack = 1'b0;
`endif

    // Directed rows with hand-written expectations
    vecs[0] = '{SPI_MODE0,  8, 4, 24'hA50000, 24'h3C0000, 1, 24'hA50000, 24'h3C0000};
    vecs[1] = '{SPI_MODE1,  8, 5, 24'h810000, 24'h7E0000, 1, 24'h810000, 24'h7E0000};
    vecs[2] = '{SPI_MODE2,  8, 5, 24'h810000, 24'h7E0000, 1, 24'h810000, 24'h7E0000};
    vecs[3] = '{SPI_MODE3,  8, 5, 24'h810000, 24'h7E0000, 1, 24'h810000, 24'h7E0000};
    vecs[4] = '{SPI_MODE0, 16, 4, 24'h123400, 24'hAA5500, 2, 24'h123400, 24'hAA5500};
    vecs[5] = '{SPI_MODE0,  5, 4, 24'hF80000, 24'h990000, 0, 24'h000000, 24'h000000};
    vecs[6] = '{SPI_MODE0,  8, 6, 24'h5A0000, 24'h660000, 1, 24'h5A0000, 24'h660000};
    // Randomized rows, expectations from the reference function
    for (int n = 7; n < NVEC; n++) begin
      sel       = int'($urandom_range(0, 2));
      rv.mode   = 2'($urandom_range(0, 3));
      rv.half   = int'($urandom_range(4, 7));
      rv.nbits  = (sel == 0) ? int'($urandom_range(1, 23)) : 8 * int'($urandom_range(1, 3));
      rv.mosi_w = 24'($urandom);
      rv.tx_w   = 24'($urandom);
      vecs[n]   = modelRow(rv);
    end

    waitClk(4);
    checkOutput("rst_busy", 32'(bus_if.busy), 32'd0);
    checkOutput("rst_oe", 32'(miso_oe), 32'd0);
    checkOutput("rst_miso", 32'(miso), 32'd0);
    checkOutput("rst_rxv", 32'(bus_if.rx_valid), 32'd0);
    checkOutput("rst_ack", 32'(bus_if.tx_ack), 32'd0);
    checkOutput("rst_rxdata", 32'(bus_if.rx_data), 32'd0);
`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
    checkOutput("rst_overrun", 32'(bus_if.overrun), 32'd0);
`endif
    rst = 1'b0;
    waitClk(4);

    for (int n = 0; n < NVEC; n++) applyStimulus(vecs[n]);

    // Reset in the middle of a word, then a fresh frame
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    bus_if.tx_data = 8'h11;
    waitClk(6);
    ss_n = 1'b0;
    mosi = 1'b1;
    waitClk(4);
    sclk = 1'b1;
    waitClk(4);
    sclk = 1'b0;
    waitClk(4);
    sclk = 1'b1;
    waitClk(4);
    checkOutput("pre_rst_busy", 32'(bus_if.busy), 32'd1);
    rst = 1'b1;
    waitClk(1);
    checkOutput("midrst_busy", 32'(bus_if.busy), 32'd0);
    checkOutput("midrst_oe", 32'(miso_oe), 32'd0);
    checkOutput("midrst_miso", 32'(miso), 32'd0);
    checkOutput("midrst_rxv", 32'(bus_if.rx_valid), 32'd0);
    checkOutput("midrst_ack", 32'(bus_if.tx_ack), 32'd0);
    checkOutput("midrst_rxdata", 32'(bus_if.rx_data), 32'd0);
    ss_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    waitClk(4);
    rst     = 1'b0;
    last_rx = 8'h00;
    waitClk(4);
    applyStimulus('{SPI_MODE0, 8, 4, 24'hC30000, 24'h960000, 1, 24'hC30000, 24'h960000});

`ifdef SPI_SLAVE_OVERRUN_FLAG_EN
    // Two words without rx_ack: one overrun on the second word
    bus_if.rx_ack = 1'b1;
    waitClk(1);
    bus_if.rx_ack = 1'b0;
    ovr_cnt  = 0;
    ack_auto = 1'b0;
    applyStimulus('{SPI_MODE0, 16, 4, 24'h0F1E00, 24'h2D3C00, 2, 24'h0F1E00, 24'h2D3C00});
    checkOutput("overrun_once", ovr_cnt, 1);
    // Same with rx_ack after each word: no overrun
    bus_if.rx_ack = 1'b1;
    waitClk(1);
    bus_if.rx_ack = 1'b0;
    ovr_cnt  = 0;
    ack_auto = 1'b1;
    applyStimulus('{SPI_MODE3, 16, 4, 24'h4B5A00, 24'h697800, 2, 24'h4B5A00, 24'h697800});
    ack_auto = 1'b0;
    checkOutput("overrun_none", ovr_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
